// File: rtl/controlador_hd.sv
// controlador_hd: bridges the CPU's HD syscall instruction to a simple
// request/acknowledge disk port.
//
// It latches the access when the instruction is decoded and stalls the
// pipeline while the disk request is outstanding. It delivers a one-cycle
// completion pulse with the read data, or with zero on a write or a timeout.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   hd_instr     HD instruction is current (held high by the control unit)
//   hd_we        1 = write to disk, 0 = read from disk
//   hd_addr      disk word address
//   hd_wdata     disk write data
//   stall        freeze PC / register write while the access is pending
//   rdata        read data for the writeback mux
//   rdata_valid  one-cycle completion qualifier
//   err          sticky timeout flag, cleared by the next accepted access
//   dk_req       disk request, high for the whole REQ state
//   dk_we        disk direction
//   dk_addr      disk address
//   dk_wdata     disk write data
//   dk_ack       disk completion
//   dk_rdata     disk read data
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for hd_instr; accepts and latches the access
// REQ   | dk_req asserted, waiting for dk_ack or for the timeout
// DONE  | access completed, rdata_valid pulse, pipeline released
// ERR   | access timed out, rdata_valid pulse with rdata = 0, err set
module controlador_hd #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hd_instr,
    input  logic              hd_we,
    input  logic [ADDR_W-1:0] hd_addr,
    input  logic [DATA_W-1:0] hd_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              dk_req,
    output logic              dk_we,
    output logic [ADDR_W-1:0] dk_addr,
    output logic [DATA_W-1:0] dk_wdata,
    input  logic              dk_ack,
    input  logic [DATA_W-1:0] dk_rdata
);

    // The counter holds values 0..TIMEOUT. REQ is left on the cycle where
    // the incremented count reaches TIMEOUT, so the counter never wraps.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             timeout_hit;

    assign wait_cnt_inc = wait_cnt + CNT_W'(1);
    assign timeout_hit  = (wait_cnt_inc == TO_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // dk_ack is checked before the timeout so a completion on the final
    // allowed cycle still counts as success.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (hd_instr) state_nx = REQ;
            REQ: begin
                if (dk_ack) begin
                    state_nx = DONE;
                end else if (timeout_hit) begin
                    state_nx = ERR;
                end
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dk_we    <= 1'b0;
            dk_addr  <= '0;
            dk_wdata <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hd_instr) begin
                        dk_we    <= hd_we;
                        dk_addr  <= hd_addr;
                        dk_wdata <= hd_wdata;
                        err      <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (dk_ack) begin
                        rdata <= dk_we ? '0 : dk_rdata;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (timeout_hit) begin
                            rdata <= '0;
                            err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Decoded straight from the state so that reset drops them immediately.
    assign dk_req      = (state == REQ);
    assign stall       = ((state == IDLE) && hd_instr) || (state == REQ);
    assign rdata_valid = (state == DONE) || (state == ERR);

endmodule

// File: tb/tb_controlador_hd.sv
module tb_controlador_hd;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          hd_instr;
    logic          hd_we;
    logic [AW-1:0] hd_addr;
    logic [DW-1:0] hd_wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          err;
    logic          dk_req;
    logic          dk_we;
    logic [AW-1:0] dk_addr;
    logic [DW-1:0] dk_wdata;
    logic          dk_ack;
    logic [DW-1:0] dk_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic err_m = 1'b0;

    controlador_hd #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .hd_instr(hd_instr), .hd_we(hd_we),
        .hd_addr(hd_addr), .hd_wdata(hd_wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .dk_req(dk_req), .dk_we(dk_we), .dk_addr(dk_addr),
        .dk_wdata(dk_wdata), .dk_ack(dk_ack), .dk_rdata(dk_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; leaves at a negedge.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            hd_instr = 1'b0;
            hd_we    = 1'($urandom);
            hd_addr  = AW'($urandom);
            hd_wdata = $urandom;
            dk_ack   = 1'($urandom);
            dk_rdata = $urandom;
            #1;
            chk("idle_stall", stall, 0);
            chk("idle_req", dk_req, 0);
            chk("idle_valid", rdata_valid, 0);
            chk("idle_err", err, err_m);
            @(negedge clk);
        end
    endtask

    // Model of one access: acknowledged on REQ cycle ack_at (1-based); an
    // ack_at outside 1..TO means no ack arrives before the timeout, which
    // ends the access after TO request cycles with err set and rdata = 0.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int ack_at,
                          input logic [DW-1:0] rd);
        int            nreq;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        exp_err = !(ack_at >= 1 && ack_at <= TO);
        nreq    = exp_err ? TO : ack_at;
        exp_rd  = (exp_err || we) ? '0 : rd;

        hd_instr = 1'b1;
        hd_we    = we;
        hd_addr  = addr;
        hd_wdata = wd;
        dk_ack   = 1'($urandom);
        dk_rdata = $urandom;
        #1;
        chk("acc_stall", stall, 1);
        chk("acc_req", dk_req, 0);
        chk("acc_valid", rdata_valid, 0);
        chk("acc_err_old", err, err_m);
        @(negedge clk);
        err_m = 1'b0;

        for (int n = 1; n <= nreq; n++) begin
            hd_we    = 1'($urandom);
            hd_addr  = AW'($urandom);
            hd_wdata = $urandom;
            dk_ack   = (n == ack_at);
            dk_rdata = (n == ack_at) ? rd : $urandom;
            #1;
            chk("req_dk_req", dk_req, 1);
            chk("req_stall", stall, 1);
            chk("req_dk_we", dk_we, we);
            chk("req_dk_addr", dk_addr, addr);
            chk("req_dk_wdata", dk_wdata, wd);
            chk("req_valid", rdata_valid, 0);
            chk("req_err", err, 0);
            @(negedge clk);
        end

        hd_instr = 1'b0;
        dk_ack   = 1'($urandom);
        dk_rdata = $urandom;
        #1;
        chk("end_valid", rdata_valid, 1);
        chk("end_stall", stall, 0);
        chk("end_dk_req", dk_req, 0);
        chk("end_rdata", rdata, exp_rd);
        chk("end_err", err, exp_err);
        err_m = exp_err;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        hd_instr = 1'b0; hd_we = 1'b0; hd_addr = '0; hd_wdata = '0;
        dk_ack = 1'b0; dk_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_req", dk_req, 0);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_dk_addr", dk_addr, 0);
        rst = 1'b0;
        idle_cycles(2);

        // Directed: read with immediate ack, write with late ack, timeout,
        // ack on the last allowed cycle, then two back-to-back reads.
        do_txn(1'b0, 16'h0010, 32'h0, 1, 32'hDEADBEEF);
        idle_cycles(1);
        do_txn(1'b1, 16'h0020, 32'h12345678, 6, 32'hCAFEF00D);
        idle_cycles(1);
        do_txn(1'b0, 16'h0030, 32'h0, 0, 32'h11111111);
        idle_cycles(2);
        do_txn(1'b0, 16'h0040, 32'h0, TO, 32'hA5A5A5A5);
        do_txn(1'b0, 16'h0001, 32'h0, 1, 32'h00000111);
        do_txn(1'b0, 16'h0002, 32'h0, 2, 32'h00000222);

        // Reset while idle with err set.
        do_txn(1'b0, 16'h0050, 32'h0, TO + 1, 32'h22222222);
        rst = 1'b1;
        #1;
        chk("rst_idle_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;
        idle_cycles(1);

        // Reset in the middle of REQ; a late ack must be ignored.
        do_txn(1'b0, 16'h0060, 32'h0, 1, 32'h76543210);
        hd_instr = 1'b1; hd_we = 1'b1; hd_addr = 16'h0BAD; hd_wdata = 32'h55AA55AA;
        dk_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_req_before", dk_req, 1);
        rst = 1'b1;
        hd_instr = 1'b0;
        #1;
        chk("mid_rst_req", dk_req, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_rdata", rdata, 0);
        chk("mid_rst_dk_we", dk_we, 0);
        chk("mid_rst_dk_addr", dk_addr, 0);
        chk("mid_rst_dk_wdata", dk_wdata, 0);
        chk("mid_rst_valid", rdata_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dk_ack = 1'b1;
            #1;
            chk("late_ack_valid", rdata_valid, 0);
            chk("late_ack_req", dk_req, 0);
            @(negedge clk);
        end

        // Randomized accesses, including timeouts and back-to-back starts.
        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom), AW'($urandom), $urandom,
                   int'($urandom_range(0, TO + 2)), $urandom);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controlador_hd.md
CONTROLADOR_HD -- requirements
Module: controlador_hd

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning disk word address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning maximum cycles waiting for dk_ack.
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port hd_instr  input  1  control-unit HD syscall decode; held high while the HD instruction is the current instruction.
REQ-007 Port hd_we  input  1  1 = write hd_wdata to disk, 0 = read disk into register file.
REQ-008 Port hd_addr  input  ADDR_W  disk word address from register operand.
REQ-009 Port hd_wdata  input  DATA_W  write data from register operand.
REQ-010 Port stall  output  1  freezes PC and register write while the disk access is in progress.
REQ-011 Port rdata  output  DATA_W  read data to the MemToReg=2 writeback path.
REQ-012 Port rdata_valid  output  1  one-cycle qualifier for completing the HD instruction.
REQ-013 Port err  output  1  sticky timeout flag.
REQ-014 Port dk_req, dk_we  output  1 each  disk request and direction.
REQ-015 Port dk_addr  output  ADDR_W  and dk_wdata  output  DATA_W  disk address and write data.
REQ-016 Port dk_ack  input  1  and dk_rdata  input  DATA_W  disk completion and read data.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, DONE, ERR.
REQ-018 In IDLE with hd_instr=1, the block SHALL latch hd_we/hd_addr/hd_wdata, clear err, clear the wait counter, and go to REQ.
REQ-019 stall SHALL be combinational: 1 when (state=IDLE and hd_instr=1) or state=REQ, else 0.
REQ-020 In REQ, dk_req SHALL be 1 and dk_we/dk_addr/dk_wdata SHALL drive the latched values, stable until the state is left.
REQ-021 In REQ with dk_ack=1, the block SHALL register dk_rdata into rdata (reads only; writes load 0) and go to DONE.
REQ-022 In REQ without dk_ack, the wait counter SHALL increment each cycle; on the cycle the counter equals TIMEOUT, the block SHALL go to ERR.
REQ-023 dk_ack arriving on the same cycle the counter equals TIMEOUT SHALL take priority (DONE, no error).
REQ-024 In DONE and in ERR, stall SHALL be 0 and rdata_valid SHALL be 1 for exactly one cycle; next state IDLE.
REQ-025 In ERR, rdata SHALL be 0 and err SHALL set; err SHALL hold until the next accepted request.
REQ-026 Minimum latency: hd_instr rising in IDLE -> rdata_valid SHALL be 2 cycles when dk_ack is high on the first REQ cycle.
REQ-027 Back-to-back HD instructions SHALL be accepted: the IDLE cycle following DONE/ERR SHALL start a new access if hd_instr=1.
REQ-028 dk_ack SHALL be ignored in IDLE, DONE and ERR.
REQ-029 Changes on hd_addr/hd_wdata/hd_we after acceptance SHALL NOT affect the access in progress.
REQ-030 The wait counter SHALL be wide enough for TIMEOUT and SHALL NOT wrap within one access.

Reset
REQ-031 On rst=1, the block SHALL immediately enter IDLE with dk_req, dk_we, rdata_valid, err = 0, rdata, dk_addr, dk_wdata, counter = 0.
REQ-032 Reset during REQ SHALL drop dk_req asynchronously; a late dk_ack after reset SHALL be ignored.

Verification
REQ-033 Read: hd_instr=1, hd_we=0, hd_addr=0x0010; dk_ack on 1st REQ cycle with dk_rdata=0xDEADBEEF -> stall high 2 cycles, rdata=0xDEADBEEF with rdata_valid pulse, dk_addr=0x0010.
REQ-034 Write: hd_we=1, hd_wdata=0x12345678, dk_ack after 5 cycles -> dk_we=1, dk_wdata=0x12345678 stable through REQ, rdata=0, rdata_valid one cycle, err=0.
REQ-035 Timeout: TIMEOUT=8, dk_ack never -> ERR after 8 REQ cycles, err=1, rdata=0, rdata_valid one cycle; err clears at next accepted request.
REQ-036 Boundary: dk_ack on the exact timeout cycle -> DONE, err=0, read data delivered.
REQ-037 Back-to-back: two consecutive reads 0x0001, 0x0002 -> two dk_req bursts separated by one IDLE cycle, both data returned in order.
REQ-038 Reset mid-REQ: assert rst during REQ -> dk_req=0 within the same cycle, outputs at reset values, subsequent dk_ack produces no rdata_valid.
